// File: rtl/pad_pkg.sv
// Shared geometry of the 4x3 pad matrix and the key-numbering helper.
package pad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [NUM_COLS-1:0] COL_IDLE_N = 3'b111;

  function automatic int key_idx(input int row, input int col);
    return row * NUM_COLS + col;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler that pulses tc for one cycle every SCAN_DIV clocks (column dwell end).
module scan_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic CLK,
  input  logic RST,
  output logic tc
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div;

  assign tc = (div == DIV_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      div <= '0;
    end else if (tc) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Column-scans the 4x3 pad, assembles one frame per full scan and debounces
// whole frames into key_vec, strobing ce_out whenever key_vec changes.
module keypad_scan_debounce
  import pad_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_COUNT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [NUM_KEYS-1:0] key_vec,
  output logic                ce_out
);

  localparam int CW = $clog2(DEB_COUNT + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEB_COUNT);

  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;

  logic                tc;
  logic [1:0]          col_idx;
  logic [NUM_KEYS-1:0] frame_buf;
  logic [NUM_KEYS-1:0] frame_next;
  logic [NUM_KEYS-1:0] raw;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_upd;
  logic                frame_done;
  logic                accept;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .CLK(CLK),
    .RST(RST),
    .tc (tc)
  );

  // Frame as it will look after this cycle's sample; the debounce compares
  // against it directly so the column-2 sample counts in the same edge.
  always_comb begin
    frame_next = frame_buf;
    for (int r = 0; r < NUM_ROWS; r++) begin
      frame_next[key_idx(r, int'(col_idx))] = ~row_n[r];
    end
  end

  assign frame_done = tc && (col_idx == COL2);

  always_comb begin
    count_upd = count;
    if (frame_next != raw) begin
      count_upd = CW'(1);
    end else if (count < COUNT_MAX) begin
      count_upd = count + CW'(1);
    end
  end

  // After the update raw always equals frame_next, so compare that to key_vec.
  assign accept = frame_done && (count_upd == COUNT_MAX) && (frame_next != key_vec);

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_idx <= COL0;
      col_n   <= 3'b110;
    end else if (tc) begin
      case (col_idx)
        COL0: begin
          col_idx <= COL1;
          col_n   <= 3'b101;
        end
        COL1: begin
          col_idx <= COL2;
          col_n   <= 3'b011;
        end
        COL2: begin
          col_idx <= COL0;
          col_n   <= 3'b110;
        end
        default: begin
          col_idx <= COL0;
          col_n   <= COL_IDLE_N;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_buf <= '0;
    end else if (tc) begin
      frame_buf <= frame_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      raw   <= '0;
      count <= '0;
    end else if (frame_done) begin
      raw   <= frame_next;
      count <= count_upd;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      key_vec <= '0;
      ce_out  <= 1'b0;
    end else begin
      ce_out <= accept;
      if (accept) begin
        key_vec <= frame_next;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEB_COUNT=2 (12-cycle frames).
module tb_keypad_scan_debounce;

  localparam int FRAME = 12;

  logic        CLK;
  logic        RST;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [11:0] key_vec;
  logic        ce_out;

  logic [11:0] pressed;
  int          check_count;
  int          pass_count;
  int          strobe_count;
  int          strobe_base;

  keypad_scan_debounce #(
    .SCAN_DIV (4),
    .DEB_COUNT(2)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .row_n  (row_n),
    .col_n  (col_n),
    .key_vec(key_vec),
    .ce_out (ce_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pad model: a row reads low when a pressed key sits on the driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!col_n[c] && pressed[r*3+c]) row_n[r] = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && ce_out) strobe_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [11:0] keys);
    pressed = keys;
  endtask

  task automatic applyReset(input int cycles);
    RST = 1'b1;
    waitCycles(cycles);
    RST = 1'b0;
  endtask

  initial begin
    check_count  = 0;
    pass_count   = 0;
    strobe_count = 0;
    pressed      = '0;
    RST          = 1'b1;
    @(negedge CLK);

    // Test 1: reset state, column stepping, idle pad never strobes
    applyReset(3);
    checkOutput("rst_col_n", 32'(col_n), 32'h6);
    checkOutput("rst_key_vec", 32'(key_vec), 32'h000);
    checkOutput("rst_ce_out", 32'(ce_out), 32'h0);
    waitCycles(3);
    checkOutput("col0_dwell_end", 32'(col_n), 32'h6);
    waitCycles(1);
    checkOutput("col1", 32'(col_n), 32'h5);
    waitCycles(4);
    checkOutput("col2", 32'(col_n), 32'h3);
    waitCycles(4);
    checkOutput("col_wrap", 32'(col_n), 32'h6);
    strobe_base = strobe_count;
    waitCycles(9 * FRAME);
    checkOutput("idle_no_strobe", 32'(strobe_count - strobe_base), 32'h0);
    checkOutput("idle_key_vec", 32'(key_vec), 32'h000);

    // Test 2: key 5 from frame 0, strobe at edge 24
    applyStimulus(12'h020);
    applyReset(3);
    strobe_base = strobe_count;
    waitCycles(2 * FRAME - 1);
    checkOutput("k5_before_ce", 32'(ce_out), 32'h0);
    checkOutput("k5_before_vec", 32'(key_vec), 32'h000);
    waitCycles(1);
    checkOutput("k5_ce", 32'(ce_out), 32'h1);
    checkOutput("k5_vec", 32'(key_vec), 32'h020);
    waitCycles(1);
    checkOutput("k5_ce_one_cycle", 32'(ce_out), 32'h0);
    waitCycles(4 * FRAME - 1);
    checkOutput("k5_held_strobes", 32'(strobe_count - strobe_base), 32'h1);

    // Test 3: release key 5 at a frame boundary
    applyStimulus(12'h000);
    strobe_base = strobe_count;
    waitCycles(FRAME);
    checkOutput("rel_one_frame_vec", 32'(key_vec), 32'h020);
    waitCycles(FRAME);
    checkOutput("rel_ce", 32'(ce_out), 32'h1);
    checkOutput("rel_vec", 32'(key_vec), 32'h000);
    waitCycles(2 * FRAME);
    checkOutput("rel_strobes", 32'(strobe_count - strobe_base), 32'h1);

    // Test 4: key 0 bounces frame by frame, never accepted
    strobe_base = strobe_count;
    applyStimulus(12'h001);
    waitCycles(FRAME);
    applyStimulus(12'h000);
    waitCycles(FRAME);
    applyStimulus(12'h001);
    waitCycles(FRAME);
    applyStimulus(12'h000);
    waitCycles(3 * FRAME);
    checkOutput("bounce_strobes", 32'(strobe_count - strobe_base), 32'h0);
    checkOutput("bounce_vec", 32'(key_vec), 32'h000);

    // Test 5: keys 0 and 11 together
    strobe_base = strobe_count;
    applyStimulus(12'h801);
    waitCycles(FRAME);
    checkOutput("multi_one_frame", 32'(key_vec), 32'h000);
    waitCycles(FRAME);
    checkOutput("multi_ce", 32'(ce_out), 32'h1);
    checkOutput("multi_vec", 32'(key_vec), 32'h801);
    waitCycles(2 * FRAME);
    checkOutput("multi_strobes", 32'(strobe_count - strobe_base), 32'h1);

    // Test 6: reset mid-debounce discards the partial count
    applyStimulus(12'h020);
    waitCycles(FRAME);
    applyReset(1);
    strobe_base = strobe_count;
    checkOutput("mid_rst_col_n", 32'(col_n), 32'h6);
    checkOutput("mid_rst_vec", 32'(key_vec), 32'h000);
    checkOutput("mid_rst_ce", 32'(ce_out), 32'h0);
    waitCycles(2 * FRAME - 1);
    checkOutput("post_rst_before", 32'(strobe_count - strobe_base), 32'h0);
    waitCycles(1);
    checkOutput("post_rst_ce", 32'(ce_out), 32'h1);
    checkOutput("post_rst_vec", 32'(key_vec), 32'h020);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
Scans the 4-row x 3-column pad matrix and debounces it into a 12-bit key vector. Emits a one-cycle load strobe whenever the debounced vector changes. Sits directly upstream of the 12-bit enable-loaded pad-state register: key_vec drives its Din, ce_out drives its Ce, and both blocks share CLK and RST.

Parameters:
SCAN_DIV, 1000, CLK cycles each column stays driven before its rows are sampled (>=2)
DEB_COUNT, 4, consecutive identical complete frames required before a change is accepted (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
row_n  input  4  matrix row sense lines, active-low (0 = key closed on driven column), externally pulled up
col_n  output  3  column drive, one-hot active-low
key_vec  output  12  debounced key state, 1 = pressed; bit index = row*3 + col
ce_out  output  1  one-cycle strobe, high in the cycle key_vec takes a new value

Behaviour:
- Reset (RST high at an edge): col_n=3'b110 (col 0), column index=0, divider=0, frame buffer=0, raw frame=0, stable count=0, key_vec=12'h000, ce_out=0. Reset mid-frame or mid-debounce discards all partial state and produces no strobe.
- Divider counts 0..SCAN_DIV-1 and wraps. Terminal count (TC) is the cycle with divider = SCAN_DIV-1.
- At TC: store ~row_n into frame bits {r*3+c} for the current column c. Then advance the column 0->1->2->0, with col_n 110->101->011->110. Each column is driven for exactly SCAN_DIV cycles. Sampling happens at the end of the dwell so the lines have settled.
- Frame complete = TC while column 2 is driven. Frame period = 3*SCAN_DIV cycles. The comparison uses the assembled frame including the column-2 sample taken at that TC.
- On frame complete:
  - If the assembled frame != raw frame: raw <= frame, stable count <= 1.
  - Otherwise: stable count <= min(count+1, DEB_COUNT).
- Accept rule: if the updated stable count == DEB_COUNT and raw (post-update) != key_vec, then at the same edge key_vec <= raw and ce_out <= 1. ce_out is 0 in all other cycles.
- Latency: a change stable from the start of a frame is reported at the edge ending the DEB_COUNT-th identical frame. With DEB_COUNT=1, the change is reported at the end of the first frame.
- Holding a pattern stable never re-strobes: count saturates and raw == key_vec.
- Bounce shorter than DEB_COUNT frames resets the count each time; key_vec is unchanged and no strobe is issued.
- Multi-key patterns are reported as seen. No ghost suppression.
- Out-of-range state cannot occur: the column index only wraps 2->0.
- key_vec and ce_out are registered outputs with no combinational path from row_n.

Decomposition:
- Package pad_pkg: NUM_ROWS=4, NUM_COLS=3, NUM_KEYS=12, function key_idx(row,col)=row*NUM_COLS+col, constant COL_IDLE_N=3'b111.
- One sub-module, scan_tick_gen: parameterised SCAN_DIV prescaler producing the TC pulse, with synchronous RST.
- Column sequencer, frame assembly and debounce stay in the top module.

Test Plan (SCAN_DIV=4, DEB_COUNT=2; frame = 12 cycles):
1. Hold RST 3 cycles, then release with row_n=4'hF -> col_n=110, key_vec=000, ce_out=0. col_n steps 110->101->011->110 every 4 cycles. No strobe over 10 frames.
2. Drive row_n[1]=0 only while col_n=011 (key 5), starting from frame 0 -> ce_out single pulse at end of frame 1 (edge 24 after release), key_vec=12'h020. No further pulses while held.
3. With key 5 held, release it -> after 2 clean frames, key_vec=12'h000 with exactly one ce_out pulse.
4. Bounce: assert key 0 (row 0, col 0) for frame 0 only, release in frame 1, assert in frame 2 only -> key_vec stays 000, ce_out never high.
5. Press keys 0 and 11 together (row0/col0 and row3/col2) -> after 2 frames, key_vec=12'h801, one strobe.
6. Key 5 stable for 1 frame, then RST pulsed for 1 cycle -> no strobe, key_vec=000, col_n=110. Keep the key held: strobe comes 2 full frames after reset release.
